ttc_count_ctrl_multi21: RTL

//  Parametrised multi-channel TTC counter control block: per-channel clock control register,

---
 rtl/ttc_pkg21.sv | 15 +
 rtl/ttc_ch_ctrl21.sv | 83 ++++++++
 rtl/ttc_count_ctrl_multi21.sv | 47 ++++
 3 files changed

// File: rtl/ttc_pkg21.sv
// ttc_pkg21: shared constants and helpers for the multi-channel TTC counter control block.
//   CTRL_EXT_SEL_BIT : external clock select bit in each channel ctrl register
//   CTRL_PS_LSB      : LSB of the prescale exponent field
//   exp_mask(e)      : 2^e - 1, the prescaler terminal count for exponent e
package ttc_pkg21;

    localparam int unsigned CTRL_EXT_SEL_BIT = 0;
    localparam int unsigned CTRL_PS_LSB      = 1;

    // Low e bits set. Callers cast the result down to their counter width.
    function automatic logic [31:0] exp_mask(input logic [31:0] e);
        return (32'd1 << e) - 32'd1;
    endfunction

endpackage

// File: rtl/ttc_ch_ctrl21.sv
// ttc_ch_ctrl21: one TTC channel's clock control register, restart-edge count enable and
// 2^e prescaler.
//   pclk         in   APB clock, rising edge
//   n_p_reset    in   async active-low reset
//   pwdata       in   ctrl register write data
//   wr_sel       in   write strobe for this channel's ctrl register
//   restart      in   per-channel restart level
//   sync_restart in   global restart level, ORed with restart
//   count_en     out  registered counter enable, low one cycle per restart rising edge
//   clk_ctrl_reg out  ctrl register contents
//   count_tick   out  registered prescaled tick, one-cycle pulse
module ttc_ch_ctrl21
    import ttc_pkg21::*;
#(
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned PS_W   = 4
) (
    input  logic              pclk,
    input  logic              n_p_reset,
    input  logic [CTRL_W-1:0] pwdata,
    input  logic              wr_sel,
    input  logic              restart,
    input  logic              sync_restart,
    output logic              count_en,
    output logic [CTRL_W-1:0] clk_ctrl_reg,
    output logic              count_tick
);

    // Counter is EMAX bits wide so e=EMAX gives a full 2^EMAX period without wrapping early.
    localparam int unsigned EMAX = (1 << PS_W) - 1;

    logic [PS_W-1:0] exp_val;
    logic [EMAX-1:0] cnt_max;
    logic [EMAX-1:0] prescaler;
    logic            restart_var;
    logic            eff_rst;
    logic            rst_edge;

    assign exp_val  = clk_ctrl_reg[CTRL_PS_LSB +: PS_W];
    assign cnt_max  = EMAX'(exp_mask(32'(exp_val)));
    assign eff_rst  = restart | sync_restart;
    assign rst_edge = eff_rst & ~restart_var;

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            clk_ctrl_reg <= '0;
            restart_var  <= 1'b0;
            count_en     <= 1'b0;
            prescaler    <= '0;
            count_tick   <= 1'b0;
        end else begin
            if (wr_sel) begin
                clk_ctrl_reg <= pwdata;
            end

            if (rst_edge) begin
                restart_var <= 1'b1;
                count_en    <= 1'b0;
                prescaler   <= '0;
                count_tick  <= 1'b0;
            end else begin
                restart_var <= eff_rst;
                count_en    <= 1'b1;
                // A write restarts the prescale period even if e is unchanged.
                if (wr_sel) begin
                    prescaler  <= '0;
                    count_tick <= 1'b0;
                end else if (count_en) begin
                    if (prescaler == cnt_max) begin
                        prescaler  <= '0;
                        count_tick <= 1'b1;
                    end else begin
                        prescaler  <= prescaler + EMAX'(1);
                        count_tick <= 1'b0;
                    end
                end else begin
                    count_tick <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ttc_count_ctrl_multi21.sv
// ttc_count_ctrl_multi21: NUM_CH independent TTC channel controllers sharing write data and a
// global synchronous restart.
//   pclk21             in   APB clock
//   n_p_reset21        in   async active-low reset
//   pwdata21           in   ctrl register write data (shared by all channels)
//   clk_ctrl_reg_sel21 in   per-channel ctrl register write select
//   restart21          in   per-channel restart level
//   sync_restart21     in   global restart, ORed into every channel
//   count_en_out21     out  per-channel counter enable
//   clk_ctrl_reg_out21 out  packed ctrl registers, channel i at [i*CTRL_W +: CTRL_W]
//   count_tick_out21   out  per-channel prescaled count tick
module ttc_count_ctrl_multi21
    import ttc_pkg21::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned PS_W   = 4
) (
    input  logic                     pclk21,
    input  logic                     n_p_reset21,
    input  logic [CTRL_W-1:0]        pwdata21,
    input  logic [NUM_CH-1:0]        clk_ctrl_reg_sel21,
    input  logic [NUM_CH-1:0]        restart21,
    input  logic                     sync_restart21,
    output logic [NUM_CH-1:0]        count_en_out21,
    output logic [NUM_CH*CTRL_W-1:0] clk_ctrl_reg_out21,
    output logic [NUM_CH-1:0]        count_tick_out21
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ttc_ch_ctrl21 #(
            .CTRL_W (CTRL_W),
            .PS_W   (PS_W)
        ) u_ch (
            .pclk         (pclk21),
            .n_p_reset    (n_p_reset21),
            .pwdata       (pwdata21),
            .wr_sel       (clk_ctrl_reg_sel21[ch]),
            .restart      (restart21[ch]),
            .sync_restart (sync_restart21),
            .count_en     (count_en_out21[ch]),
            .clk_ctrl_reg (clk_ctrl_reg_out21[ch*CTRL_W +: CTRL_W]),
            .count_tick   (count_tick_out21[ch])
        );
    end

endmodule
